spi_minion_frontend: RTL and testbench

Pad-side SPI minion front end. It synchronizes the raw `cs`/`sclk`/`mosi` GPIO inputs into the `clk` domain and deserializes fixed-width MOSI packets into a one-entry val/rdy stream. It also serializes one outgoing val/rdy word per transaction onto `miso`. It sits directly upstream of the tape-in interconnect: its recv stream feeds the interconnect's SPI adapter, and its send stream is driven by the interconnect's return path.

---
 rtl/spi_frontend_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 42 ++++
 rtl/spi_minion_frontend.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_minion_frontend.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_frontend_pkg
// Description : Shared types and constants for the SPI minion front end.
//               Holds the front-end state encoding and the synchronizer depth.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_frontend_pkg;

   // Number of flops in each raw-pin synchronizer chain.
   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage : spi_frontend_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit flop-chain synchronizer for a raw pad input that
//               is asynchronous to clk. Chain depth is SYNC_STAGES.
// Ports       : clk      - destination clock
//               reset_n  - asynchronous active-low reset
//               d        - raw asynchronous input
//               q        - synchronized output
// Parameters  : RESET_VAL - value every stage takes while in reset
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
   import spi_frontend_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/spi_minion_frontend.sv
`default_nettype none
// ============================================================================
// Module      : spi_minion_frontend
// Description : Pad-side SPI minion (mode 0, MSB first). Synchronizes raw
//               cs/sclk/mosi into clk, deserializes one BIT_WIDTH packet per
//               cs-low window into a one-entry val/rdy buffer, and serializes
//               one val/rdy send word per transaction onto miso.
// Ports       : clk, reset_n             - clock, async active-low reset
//               cs, sclk, mosi           - raw SPI pins (asynchronous)
//               miso                     - registered serial data out
//               recv_msg/val/rdy         - received packet stream
//               send_msg/val/rdy         - transmit word stream
//               parity                   - XOR of recv_msg, registered
//               overflow                 - sticky dropped-packet flag
// Revision    : 1.0 - initial release
// ============================================================================
module spi_minion_frontend
   import spi_frontend_pkg::*;
#(
   parameter int BIT_WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cs,
   input  logic                 sclk,
   input  logic                 mosi,
   output logic                 miso,
   output logic [BIT_WIDTH-1:0] recv_msg,
   output logic                 recv_val,
   input  logic                 recv_rdy,
   input  logic [BIT_WIDTH-1:0] send_msg,
   input  logic                 send_val,
   output logic                 send_rdy,
   output logic                 parity,
   output logic                 overflow
);

   localparam int                  CNT_W       = $clog2(BIT_WIDTH + 1);
   localparam logic [CNT_W-1:0]    FULL_CNT    = CNT_W'(BIT_WIDTH);
   localparam int                  SETTLE_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

   // ------------------------------------------------------------------
   // Synchronizers. cs idles high so its chain resets to 1.
   // ------------------------------------------------------------------
   logic cs_sync;
   logic sclk_sync;
   logic mosi_sync;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (cs),
      .q       (cs_sync)
   );

   sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sclk),
      .q       (sclk_sync)
   );

   sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (mosi),
      .q       (mosi_sync)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e                state_q,     state_d;
   logic                  cs_dly_q,    cs_dly_d;
   logic                  sclk_dly_q,  sclk_dly_d;
   logic [BIT_WIDTH-1:0]  rx_shift_q,  rx_shift_d;
   logic [BIT_WIDTH-1:0]  tx_shift_q,  tx_shift_d;
   logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic                  overrun_q,   overrun_d;
   logic                  miso_q,      miso_d;
   logic [BIT_WIDTH-1:0]  recv_msg_q,  recv_msg_d;
   logic                  recv_val_q,  recv_val_d;
   logic                  send_rdy_q,  send_rdy_d;
   logic                  parity_q,    parity_d;
   logic                  overflow_q,  overflow_d;
   logic                  armed_q,     armed_d;
   logic [SETTLE_W-1:0]   settle_q,    settle_d;

   logic cs_rise;
   logic cs_fall;
   logic sclk_rise;
   logic sclk_fall;
   logic settled;
   logic frame_ok;

   assign settled   = (settle_q == SETTLE_DONE);
   assign cs_rise   =  cs_sync   & ~cs_dly_q;
   // A falling edge only counts once cs has been seen high after reset, so
   // a transaction already in flight when reset releases is ignored.
   assign cs_fall   = ~cs_sync   &  cs_dly_q & armed_q;
   assign sclk_rise =  sclk_sync & ~sclk_dly_q;
   assign sclk_fall = ~sclk_sync &  sclk_dly_q;
   // Exactly BIT_WIDTH rising edges: counter reached full and never overran.
   assign frame_ok  = (bit_cnt_q == FULL_CNT) && !overrun_q;

   always_comb begin
      state_d    = state_q;
      cs_dly_d   = cs_sync;
      sclk_dly_d = sclk_sync;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      overrun_d  = overrun_q;
      miso_d     = 1'b0;
      recv_msg_d = recv_msg_q;
      recv_val_d = recv_val_q;
      send_rdy_d = 1'b0;
      parity_d   = parity_q;
      overflow_d = overflow_q;
      armed_d    = armed_q;
      settle_d   = settle_q;

      // Synchronizer outputs are only meaningful once the reset value has
      // flushed through the chain.
      if (!settled) begin
         settle_d = settle_q + SETTLE_W'(1);
      end
      if (!armed_q && settled && cs_sync) begin
         armed_d = 1'b1;
      end

      // Consumer drain; a commit in DONE below overrides this.
      if (recv_val_q && recv_rdy) begin
         recv_val_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = ACTIVE;
               bit_cnt_d = '0;
               overrun_d = 1'b0;
               if (send_val) begin
                  tx_shift_d = send_msg;
                  send_rdy_d = 1'b1;
               end else begin
                  tx_shift_d = '0;
               end
            end
         end

         ACTIVE: begin
            miso_d = tx_shift_q[BIT_WIDTH-1];
            if (cs_rise) begin
               state_d = DONE;
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[BIT_WIDTH-2:0], mosi_sync};
                  if (bit_cnt_q == FULL_CNT) begin
                     overrun_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
               if (sclk_fall) begin
                  tx_shift_d = {tx_shift_q[BIT_WIDTH-2:0], 1'b0};
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            if (frame_ok) begin
               if (!recv_val_q || recv_rdy) begin
                  recv_msg_d = rx_shift_q;
                  parity_d   = ^rx_shift_q;
                  recv_val_d = 1'b1;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cs_dly_q   <= 1'b1;
         sclk_dly_q <= 1'b0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         bit_cnt_q  <= '0;
         overrun_q  <= 1'b0;
         miso_q     <= 1'b0;
         recv_msg_q <= '0;
         recv_val_q <= 1'b0;
         send_rdy_q <= 1'b0;
         parity_q   <= 1'b0;
         overflow_q <= 1'b0;
         armed_q    <= 1'b0;
         settle_q   <= '0;
      end else begin
         state_q    <= state_d;
         cs_dly_q   <= cs_dly_d;
         sclk_dly_q <= sclk_dly_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         overrun_q  <= overrun_d;
         miso_q     <= miso_d;
         recv_msg_q <= recv_msg_d;
         recv_val_q <= recv_val_d;
         send_rdy_q <= send_rdy_d;
         parity_q   <= parity_d;
         overflow_q <= overflow_d;
         armed_q    <= armed_d;
         settle_q   <= settle_d;
      end
   end

   assign miso     = miso_q;
   assign recv_msg = recv_msg_q;
   assign recv_val = recv_val_q;
   assign send_rdy = send_rdy_q;
   assign parity   = parity_q;
   assign overflow = overflow_q;

endmodule : spi_minion_frontend
`default_nettype wire

// File: tb/tb_spi_minion_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_minion_frontend
// Description : Self-checking bench for spi_minion_frontend. Drives the raw
//               SPI pins as a mode-0 master and compares against a
//               transaction-level model of the receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_minion_frontend;

   localparam int BW = 20;
   localparam int PH = 6;   // clk periods per sclk phase / cs setup / hold

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic          cs       = 1'b1;
   logic          sclk     = 1'b0;
   logic          mosi     = 1'b0;
   logic          recv_rdy = 1'b1;
   logic          send_val = 1'b0;
   logic [BW-1:0] send_msg = '0;
   logic          miso;
   logic [BW-1:0] recv_msg;
   logic          recv_val;
   logic          send_rdy;
   logic          parity;
   logic          overflow;

   always #5 clk = ~clk;

   spi_minion_frontend #(.BIT_WIDTH(BW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cs       (cs),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .recv_msg (recv_msg),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .send_msg (send_msg),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .parity   (parity),
      .overflow (overflow)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit            mdl_full = 1'b0;
   logic [BW-1:0] mdl_data = '0;
   bit            mdl_ovf  = 1'b0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] got_q[$];
   int            send_cnt     = 0;
   int            exp_send_cnt = 0;

   // Observers sample 2 time units after the falling edge; drivers only
   // change on the falling edge itself.
   always @(negedge clk) begin
      #2;
      if (recv_val && recv_rdy) got_q.push_back(recv_msg);
      if (send_rdy) send_cnt++;
   end

   // A complete frame arrives; rdy_pulse means the consumer was ready exactly
   // on the commit cycle and dropped ready again afterwards.
   task automatic mdl_commit(input logic [BW-1:0] pkt, input bit rdy_pulse);
      if (mdl_full && (rdy_pulse || recv_rdy)) begin
         exp_q.push_back(mdl_data);
         mdl_full = 1'b0;
      end
      if (!mdl_full) begin
         mdl_data = pkt;
         mdl_full = 1'b1;
      end else begin
         mdl_ovf = 1'b1;
      end
      if (mdl_full && recv_rdy) begin
         exp_q.push_back(mdl_data);
         mdl_full = 1'b0;
      end
   endtask

   task automatic check_state(input string tag);
      check_val({tag, ".recv_val"}, recv_val, mdl_full);
      check_val({tag, ".recv_msg"}, recv_msg, mdl_data);
      check_val({tag, ".parity"},   parity,   ^mdl_data);
      check_val({tag, ".overflow"}, overflow, mdl_ovf);
      check_val({tag, ".send_cnt"}, send_cnt, exp_send_cnt);
      while (exp_q.size() > 0) begin
         logic [BW-1:0] e;
         e = exp_q.pop_front();
         if (got_q.size() == 0) begin
            check_val({tag, ".drain_missing"}, 32'hDEAD, e);
         end else begin
            check_val({tag, ".drain"}, got_q.pop_front(), e);
         end
      end
      check_val({tag, ".drain_extra"}, got_q.size(), 0);
      got_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".miso"},     miso,     0);
      check_val({tag, ".recv_msg"}, recv_msg, 0);
      check_val({tag, ".recv_val"}, recv_val, 0);
      check_val({tag, ".send_rdy"}, send_rdy, 0);
      check_val({tag, ".parity"},   parity,   0);
      check_val({tag, ".overflow"}, overflow, 0);
   endtask

   // ---------------- SPI master ----------------
   task automatic cs_low(input bit sv, input logic [BW-1:0] sm);
      @(negedge clk);
      send_val = sv;
      send_msg = sm;
      cs       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      check_val("send_rdy_pulse", send_rdy, sv);
      if (sv) exp_send_cnt++;
      send_val = 1'b0;
      @(negedge clk);
      #2;
      check_val("send_rdy_single", send_rdy, 0);
      repeat (PH) @(negedge clk);
   endtask

   task automatic shift_bit(input logic b, output logic m);
      mosi = b;
      repeat (PH) @(negedge clk);
      m    = miso;
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic cs_high(input bit rdy_pulse);
      repeat (PH) @(negedge clk);
      cs = 1'b1;
      if (rdy_pulse) begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         recv_rdy = 1'b1;
         @(posedge clk);
         @(negedge clk);
         recv_rdy = 1'b0;
         repeat (PH) @(negedge clk);
      end else begin
         repeat (PH + 2) @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [BW-1:0] pkt, input int nbits,
                      input bit sv, input logic [BW-1:0] sm, input bit rdy_pulse);
      logic [BW-1:0] mw;
      logic          m;
      mw = '0;
      cs_low(sv, sm);
      for (int i = 0; i < nbits; i++) begin
         shift_bit(pkt[BW-1-i], m);
         mw[BW-1-i] = m;
      end
      cs_high(rdy_pulse);
      if (nbits == BW) begin
         mdl_commit(pkt, rdy_pulse);
         check_val({tag, ".miso"}, mw, sv ? sm : '0);
      end
      check_state(tag);
   endtask

   task automatic set_rdy(input logic v);
      @(negedge clk);
      recv_rdy = v;
      if (v && mdl_full) begin
         exp_q.push_back(mdl_data);
         mdl_full = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic          m;
      logic [BW-1:0] pkt;
      logic [BW-1:0] sm;
      bit            sv;

      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (6) @(negedge clk);

      run("basic",  20'hA5A5A, BW, 1'b1, 20'h12345, 1'b0);
      run("nosend", 20'h00001, BW, 1'b0, 20'h54321, 1'b0);

      run("short",  20'h9C3E1, 12, 1'b1, 20'hBEEF1, 1'b0);
      run("after_short", 20'hFFFFF, BW, 1'b0, 20'h0, 1'b0);

      set_rdy(1'b0);
      run("bp1", 20'h11111, BW, 1'b0, 20'h0, 1'b0);
      run("bp2", 20'h22222, BW, 1'b0, 20'h0, 1'b0);
      set_rdy(1'b1);
      check_state("bp_drain");

      // Reset in the middle of a transaction, released while cs is still low.
      cs_low(1'b1, 20'h3C3C3);
      for (int i = 0; i < 10; i++) shift_bit(1'b1, m);
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      check_reset_outputs("midreset");
      mdl_full = 1'b0;
      mdl_data = '0;
      mdl_ovf  = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) shift_bit(1'b0, m);
      cs_high(1'b0);
      check_state("after_reset_ignored");
      run("after_reset", 20'h6B2D9, BW, 1'b1, 20'hC0FFE, 1'b0);

      set_rdy(1'b0);
      run("refill_a", 20'hAAAAA, BW, 1'b0, 20'h0, 1'b0);
      run("refill_b", 20'h55555, BW, 1'b1, 20'h0F0F0, 1'b1);
      set_rdy(1'b1);
      check_state("refill_drain");

      for (int t = 0; t < 10; t++) begin
         pkt = BW'($urandom);
         sm  = BW'($urandom);
         sv  = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) set_rdy(~recv_rdy);
         run("rand", pkt, BW, sv, sm, 1'b0);
      end
      set_rdy(1'b1);
      check_state("final");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_spi_minion_frontend
`default_nettype wire
